// File: rtl/flash_port_arbiter.sv
// flash_port_arbiter: two-requester round-robin arbiter for the RAM-BIOS internal port,
// with an in-order ID FIFO that steers registered read responses back to their owner.
module flash_port_arbiter #(
    parameter int TAGW  = 21,
    parameter int DEPTH = 4
) (
    input  logic            CLKH,
    input  logic            RESET,
    input  logic            ACT0,
    input  logic            ACT1,
    input  logic            CMD0,
    input  logic            CMD1,
    input  logic [31:0]     ADDR0,
    input  logic [31:0]     ADDR1,
    input  logic [7:0]      BE0,
    input  logic [7:0]      BE1,
    input  logic [63:0]     DTI0,
    input  logic [63:0]     DTI1,
    input  logic [TAGW-1:0] TAGI0,
    input  logic [TAGW-1:0] TAGI1,
    output logic            NEXT0,
    output logic            NEXT1,
    output logic            DRDY0,
    output logic            DRDY1,
    output logic [63:0]     DTO0,
    output logic [63:0]     DTO1,
    output logic [TAGW-1:0] TAGO0,
    output logic [TAGW-1:0] TAGO1,
    input  logic            MNEXT,
    output logic            MACT,
    output logic            MCMD,
    output logic [31:0]     MADDR,
    output logic [7:0]      MBE,
    output logic [63:0]     MDTI,
    output logic [TAGW-1:0] MTAGI,
    input  logic            MDRDY,
    input  logic [63:0]     MDTO,
    input  logic [TAGW-1:0] MTAGO,
    output logic            ERR
);
    localparam int AW = $clog2(DEPTH);

    logic             last, el0, el1, gnt, gid, acc, push, pop, full, empty;
    logic [AW-1:0]    wp, rp;
    logic [AW:0]      cnt;
    logic [DEPTH-1:0] ids;

    assign full  = cnt == (AW+1)'(DEPTH);
    assign empty = cnt == '0;
    // a full FIFO only blocks reads; writes never need a response slot
    assign el0   = ACT0 & (~CMD0 | ~full);
    assign el1   = ACT1 & (~CMD1 | ~full);
    assign gnt   = el0 | el1;
    assign gid   = (el0 & el1) ? ~last : el1;

    assign MACT  = gnt;
    assign MCMD  = gnt & (gid ? CMD1 : CMD0);
    assign MADDR = gnt ? (gid ? ADDR1 : ADDR0) : '0;
    assign MBE   = gnt ? (gid ? BE1 : BE0) : 8'hFF;
    assign MDTI  = gnt ? (gid ? DTI1 : DTI0) : '0;
    assign MTAGI = gnt ? (gid ? TAGI1 : TAGI0) : '0;
    assign NEXT0 = gnt & ~gid & MNEXT;
    assign NEXT1 = gnt & gid & MNEXT;

    assign acc   = gnt & MNEXT;
    assign push  = acc & MCMD;
    assign pop   = MDRDY & ~empty;

    always_ff @(posedge CLKH or negedge RESET) begin
        if (!RESET) begin
            last  <= 1'b1;
            wp    <= '0;
            rp    <= '0;
            cnt   <= '0;
            DRDY0 <= 1'b0;
            DRDY1 <= 1'b0;
            DTO0  <= '0;
            DTO1  <= '0;
            TAGO0 <= '0;
            TAGO1 <= '0;
            ERR   <= 1'b0;
        end else begin
            if (acc) last <= gid;
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            cnt   <= cnt + (AW+1)'(push) - (AW+1)'(pop);
            DRDY0 <= pop & ~ids[rp];
            DRDY1 <= pop & ids[rp];
            if (MDRDY) begin
                DTO0  <= MDTO;
                DTO1  <= MDTO;
                TAGO0 <= MTAGO;
                TAGO1 <= MTAGO;
            end
            if (MDRDY & empty) ERR <= 1'b1;
        end
    end

    always_ff @(posedge CLKH) begin
        if (push) ids[wp] <= gid;
    end
endmodule

// File: tb/tb_flash_port_arbiter.sv
// tb_flash_port_arbiter: directed stimulus with a 2-cycle memory model and a
// scoreboard monitor that checks every routed read response.
module tb_flash_port_arbiter;
    localparam int TAGW = 21;

    logic            CLKH = 0, RESET = 0;
    logic            ACT0 = 0, ACT1 = 0, CMD0 = 0, CMD1 = 0;
    logic [31:0]     ADDR0 = 0, ADDR1 = 0;
    logic [7:0]      BE0 = 8'hFF, BE1 = 8'hFF;
    logic [63:0]     DTI0 = 0, DTI1 = 0;
    logic [TAGW-1:0] TAGI0 = 0, TAGI1 = 0;
    logic            NEXT0, NEXT1, DRDY0, DRDY1;
    logic [63:0]     DTO0, DTO1;
    logic [TAGW-1:0] TAGO0, TAGO1;
    logic            MNEXT = 1, MACT, MCMD;
    logic [31:0]     MADDR;
    logic [7:0]      MBE;
    logic [63:0]     MDTI;
    logic [TAGW-1:0] MTAGI;
    logic            MDRDY = 0;
    logic [63:0]     MDTO = 0;
    logic [TAGW-1:0] MTAGO = 0;
    logic            ERR;

    flash_port_arbiter #(.TAGW(TAGW), .DEPTH(4)) dut (
        .CLKH(CLKH), .RESET(RESET),
        .ACT0(ACT0), .ACT1(ACT1), .CMD0(CMD0), .CMD1(CMD1),
        .ADDR0(ADDR0), .ADDR1(ADDR1), .BE0(BE0), .BE1(BE1),
        .DTI0(DTI0), .DTI1(DTI1), .TAGI0(TAGI0), .TAGI1(TAGI1),
        .NEXT0(NEXT0), .NEXT1(NEXT1), .DRDY0(DRDY0), .DRDY1(DRDY1),
        .DTO0(DTO0), .DTO1(DTO1), .TAGO0(TAGO0), .TAGO1(TAGO1),
        .MNEXT(MNEXT), .MACT(MACT), .MCMD(MCMD), .MADDR(MADDR),
        .MBE(MBE), .MDTI(MDTI), .MTAGI(MTAGI),
        .MDRDY(MDRDY), .MDTO(MDTO), .MTAGO(MTAGO), .ERR(ERR)
    );

    always #5 CLKH = ~CLKH;

    typedef struct {
        logic            id;
        logic [63:0]     d;
        logic [TAGW-1:0] t;
        int              cyc;
    } exp_t;
    typedef struct {
        logic [63:0]     d;
        logic [TAGW-1:0] t;
        int              rdy;
    } mem_t;

    exp_t sb[$];
    mem_t mq[$];
    int   passed = 0, total = 0, cyc = 0, rel = 0;
    logic hold = 0, err_pulse = 0;

    always @(posedge CLKH) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [63:0] mdata(input logic [31:0] a);
        return (a == 32'h40) ? 64'h1122334455667788 : {a, a ^ 32'hA5A5A5A5};
    endfunction

    // Response monitor plus memory model, both evaluated mid-cycle
    always @(negedge CLKH) begin
        if (DRDY0 | DRDY1) begin
            if (sb.size() == 0) chk("unexpected_drdy", {DRDY1, DRDY0}, 2'b00);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("drdy_owner", {DRDY1, DRDY0}, e.id ? 2'b10 : 2'b01);
                chk("dto", DRDY1 ? DTO1 : DTO0, e.d);
                chk("dto_bcast", DTO1, DTO0);
                chk("tago", DRDY1 ? TAGO1 : TAGO0, e.t);
                if (e.cyc >= 0) chk("latency", cyc, e.cyc);
            end
        end
        MDRDY = 0;
        if (err_pulse) begin
            MDRDY = 1; MDTO = 64'hDEAD_BEEF_0BAD_F00D; MTAGO = '1; err_pulse = 0;
        end else if (mq.size() > 0 && mq[0].rdy <= cyc && (!hold || rel > 0)) begin
            mem_t r;
            r = mq.pop_front();
            MDRDY = 1; MDTO = r.d; MTAGO = r.t;
            if (hold) rel--;
        end
        if (RESET && MACT && MNEXT && MCMD) mq.push_back('{mdata(MADDR), MTAGI, cyc + 2});
    end

    task automatic drv(input logic a0, c0, input logic [31:0] ad0, input logic [7:0] b0,
                       input logic [TAGW-1:0] t0, input logic a1, c1, input logic [31:0] ad1,
                       input logic [7:0] b1, input logic [TAGW-1:0] t1, input logic mn);
        @(posedge CLKH); #1;
        ACT0 = a0; CMD0 = c0; ADDR0 = ad0; BE0 = b0; DTI0 = {ad0, ~ad0}; TAGI0 = t0;
        ACT1 = a1; CMD1 = c1; ADDR1 = ad1; BE1 = b1; DTI1 = {ad1, ~ad1}; TAGI1 = t1;
        MNEXT = mn;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drv(0, 0, 0, 8'hFF, 0, 0, 0, 0, 8'hFF, 0, 1);
    endtask

    task automatic rd_exp(input logic id, input logic [31:0] a, input logic [TAGW-1:0] t, input int c);
        sb.push_back('{id, mdata(a), t, c});
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] gt;
        int n0, n1;
        #3;
        chk("rst_drdy", {DRDY1, DRDY0}, 0);
        chk("rst_dto", DTO0 | DTO1, 0);
        chk("rst_tago", {TAGO1, TAGO0}, 0);
        chk("rst_err", ERR, 0);
        chk("rst_mact", MACT, 0);
        chk("idle_mbe", MBE, 8'hFF);
        @(negedge CLKH); @(negedge CLKH); RESET = 1;

        // single read
        drv(1, 1, 32'h40, 8'hFF, 21'h00155, 0, 0, 0, 8'hFF, 0, 1);
        chk("t1_next0", NEXT0, 1);
        chk("t1_next1", NEXT1, 0);
        chk("t1_mcmd", MCMD, 1);
        chk("t1_maddr", MADDR, 32'h40);
        chk("t1_mtagi", MTAGI, 21'h00155);
        sb.push_back('{1'b0, 64'h1122334455667788, 21'h00155, cyc + 3});
        idle(6);

        // contention right after reset: requester 0 wins first
        @(negedge CLKH); #1 RESET = 0; mq.delete();
        @(negedge CLKH); #1 RESET = 1;
        gt = 4'b1010; n0 = 0; n1 = 0;
        for (int i = 0; i < 4; i++) begin
            drv(1, 1, 32'h100 + n0 * 8, 8'hFF, 21'h1000 + n0, 1, 1, 32'h200 + n1 * 8, 8'hFF, 21'h2000 + n1, 1);
            chk("t2_next0", NEXT0, !gt[i]);
            chk("t2_next1", NEXT1, gt[i]);
            if (gt[i]) begin rd_exp(1, 32'h200 + n1 * 8, 21'h2000 + n1, cyc + 3); n1++; end
            else begin rd_exp(0, 32'h100 + n0 * 8, 21'h1000 + n0, cyc + 3); n0++; end
        end
        idle(6);

        // FIFO full: reads blocked, other requester's write still goes through
        hold = 1; rel = 0;
        for (int i = 0; i < 4; i++) begin
            drv(1, 1, 32'h300 + i * 8, 8'hFF, 21'h3000 + i, 0, 0, 0, 8'hFF, 0, 1);
            chk("t3_fill_next0", NEXT0, 1);
            rd_exp(0, 32'h300 + i * 8, 21'h3000 + i, -1);
        end
        drv(1, 1, 32'h320, 8'hFF, 21'h3004, 1, 0, 32'h400, 8'hF0, 21'h4000, 1);
        chk("t3_full_next0", NEXT0, 0);
        chk("t3_wr_next1", NEXT1, 1);
        chk("t3_wr_mact", MACT, 1);
        chk("t3_wr_mbe", MBE, 8'hF0);
        chk("t3_wr_mcmd", MCMD, 0);
        chk("t3_wr_maddr", MADDR, 32'h400);
        chk("t3_wr_mdti", MDTI, 64'h00000400_FFFFFBFF);
        drv(1, 1, 32'h320, 8'hFF, 21'h3004, 0, 0, 0, 8'hFF, 0, 1);
        rel = 1;
        chk("t3_pop_cycle_next0", NEXT0, 0);
        drv(1, 1, 32'h320, 8'hFF, 21'h3004, 0, 0, 0, 8'hFF, 0, 1);
        chk("t3_after_pop_next0", NEXT0, 1);
        rd_exp(0, 32'h320, 21'h3004, -1);
        hold = 0;
        idle(8);

        // streaming reads: push and pop together, pointers wrap
        for (int i = 0; i < 10; i++) begin
            drv(1, 1, 32'h500 + i * 8, 8'hFF, 21'h5000 + i, 0, 0, 0, 8'hFF, 0, 1);
            chk("t4_next0", NEXT0, 1);
            rd_exp(0, 32'h500 + i * 8, 21'h5000 + i, cyc + 3);
        end
        idle(6);

        // stall with LAST = 0: requester 1 holds the grant without rotating
        drv(1, 0, 32'h600, 8'h00, 0, 0, 0, 0, 8'hFF, 0, 1);
        chk("t5_wr_next0", NEXT0, 1);
        for (int i = 0; i < 3; i++) begin
            drv(1, 1, 32'h700, 8'hFF, 21'h7000, 1, 1, 32'h710, 8'hFF, 21'h7100, 0);
            chk("t5_stall_mact", MACT, 1);
            chk("t5_stall_next", {NEXT1, NEXT0}, 0);
            chk("t5_stall_maddr", MADDR, 32'h710);
        end
        drv(1, 1, 32'h700, 8'hFF, 21'h7000, 1, 1, 32'h710, 8'hFF, 21'h7100, 1);
        chk("t5_go_next", {NEXT1, NEXT0}, 2'b10);
        rd_exp(1, 32'h710, 21'h7100, cyc + 3);
        drv(1, 1, 32'h700, 8'hFF, 21'h7000, 1, 1, 32'h718, 8'hFF, 21'h7101, 1);
        chk("t5_rot_next", {NEXT1, NEXT0}, 2'b01);
        rd_exp(0, 32'h700, 21'h7000, cyc + 3);
        idle(6);

        // response with nothing outstanding, then reset in the middle of a read
        idle(1);
        err_pulse = 1;
        idle(1);
        chk("t6_err_set", ERR, 1);
        idle(1);
        chk("t6_err_sticky", ERR, 1);
        drv(1, 1, 32'h800, 8'hFF, 21'h8000, 0, 0, 0, 8'hFF, 0, 1);
        chk("t6_rd_next0", NEXT0, 1);
        idle(1);
        #1 RESET = 0;
        mq.delete();
        #1;
        chk("t6_rst_drdy", {DRDY1, DRDY0}, 0);
        chk("t6_rst_dto0", DTO0, 0);
        chk("t6_rst_dto1", DTO1, 0);
        chk("t6_rst_tago", {TAGO1, TAGO0}, 0);
        chk("t6_rst_err", ERR, 0);
        @(negedge CLKH); #1 RESET = 1;
        idle(4);
        chk("t6_err_after", ERR, 0);
        chk("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/flash_port_arbiter.md
Name: flash_port_arbiter

Overview:
- Two-requester round-robin arbiter sharing the single internal-interface port of the RAM-BIOS memory block.
- Typical requesters: requester 0 is the CPU core fetch/load port; requester 1 is the BIOS loader/DMA.
- Request path is combinational pass-through, so the memory samples the granted request in the same cycle.
- The arbiter tracks outstanding reads in an in-order ID FIFO and routes each read response to its owner through a registered response stage.

Parameters:
- TAGW, 21, width of the transaction tag carried with each request and response.
- DEPTH, 4, maximum number of outstanding reads; must be a power of 2, minimum 2.

Ports:
- CLKH  in  1  clock.
- RESET  in  1  asynchronous active-low reset.
- ACT0/ACT1  in  1  request valid, requester 0/1.
- CMD0/CMD1  in  1  1 = read, 0 = write.
- ADDR0/ADDR1  in  32  byte address.
- BE0/BE1  in  8  byte enables, active-low; used for writes.
- DTI0/DTI1  in  64  write data.
- TAGI0/TAGI1  in  TAGW  request tag.
- NEXT0/NEXT1  out  1  request accepted this cycle when ACTx & NEXTx.
- DRDY0/DRDY1  out  1  read data valid for requester 0/1.
- DTO0/DTO1  out  64  read data.
- TAGO0/TAGO1  out  TAGW  returned tag.
- MNEXT  in  1  memory ready.
- MACT, MCMD, MADDR[31:0], MBE[7:0], MDTI[63:0], MTAGI[TAGW-1:0]  out  –  memory request.
- MDRDY  in  1  memory read response valid.
- MDTO  in  64  memory read data.
- MTAGO  in  TAGW  memory response tag.
- ERR  out  1  sticky protocol error flag.

Behaviour:
- Eligibility: requester x is eligible when ACTx & (~CMDx | ~full). Writes are never blocked by a full FIFO.
- Grant (combinational):
  - Only one eligible requester: it is granted.
  - Both eligible: the one not recorded in register LAST is granted.
  - Neither eligible: no grant.
- Memory request outputs:
  - MACT = granted & eligible.
  - MCMD, MADDR, MBE, MDTI, MTAGI are muxed from the granted requester.
  - With no grant: MADDR = 0, MBE = 8'hFF, MCMD = 0, MTAGI = 0, MDTI = 0.
- NEXTx = (grant == x) & eligible_x & MNEXT. NEXT of the non-granted requester is 0.
- Accept = MACT & MNEXT.
  - On accept, LAST <= granted ID.
  - Without an accept, LAST is unchanged, so a stalled grant does not rotate priority.
- Read tracking FIFO:
  - On accept with MCMD = 1, push the granted ID.
  - On MDRDY, pop the head.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Pointers wrap modulo DEPTH.
  - full = (count == DEPTH); empty = (count == 0).
  - Writes push nothing; write completion is not signalled.
- Response stage, registered, one cycle after MDRDY:
  - DRDY[head] <= 1; DRDY of the other requester <= 0.
  - DTO0 = DTO1 <= MDTO; TAGO0 = TAGO1 <= MTAGO. Data is broadcast; only DRDY qualifies it.
  - DRDYx <= 0 in cycles without MDRDY. DTO/TAGO hold their last value.
- Read latency seen by a requester: memory latency + 1 cycle. With the current memory (DRDY 2 cycles after accept), DRDYx asserts 3 cycles after the accept edge.
- Error: MDRDY while the FIFO is empty sets ERR = 1 (sticky until reset). No pop occurs and both DRDY stay 0.
- Reset (asynchronous, RESET low):
  - DRDY0 = DRDY1 = 0; DTO0/1 = 0; TAGO0/1 = 0; ERR = 0.
  - FIFO empty, pointers = 0.
  - LAST = 1, so requester 0 wins the first contention.
  - Reset mid-transaction discards outstanding reads. Memory responses arriving after reset, with the FIFO empty, set ERR. The integration requires memory and arbiter to share RESET.
- FIFO full with one pending read: the other requester's write is still granted and accepted in that cycle.

Test Plan:
- Single read: ACT0 = 1, CMD0 = 1, ADDR0 = 0x0000_0040, TAGI0 = 0x00155, MNEXT = 1, model memory with 2-cycle latency returning 0x1122334455667788 -> NEXT0 = 1 in cycle 0; DRDY0 = 1 in cycle 3 with DTO0 = 0x1122334455667788 and TAGO0 = 0x00155; DRDY1 stays 0.
- Contention after reset: both requesters issue back-to-back reads for 4 cycles -> grants alternate 0, 1, 0, 1; responses return DRDY0, DRDY1, DRDY0, DRDY1 in order with matching tags.
- FIFO full: MDRDY held 0, requester 0 issues 4 reads -> 5th read sees NEXT0 = 0. Requester 1 write with BE1 = 8'hF0 in the same cycle -> NEXT1 = 1, MBE = 8'hF0, MCMD = 0. One MDRDY -> read accepted the cycle after the pop.
- Simultaneous push/pop: count at 2; in one cycle a read is accepted and MDRDY = 1 -> count stays 2; response goes to the old head; subsequent order preserved across pointer wrap (run 10 reads).
- MNEXT = 0 stall: both requesters active, LAST = 0 -> grant = 1, NEXT1 = 0, LAST unchanged for 3 stall cycles; MNEXT = 1 -> requester 1 accepted, then requester 0.
- Error and reset: MDRDY pulse with the FIFO empty -> ERR = 1, no DRDY. Assert RESET low mid-read -> all outputs 0 asynchronously, ERR cleared.
